// File: rtl/synth_pkg.sv
// Shared definitions for the synth audio path: the sample type, mixer FSM states,
// gain constants and the 16-bit saturation helper that later effect stages reuse.
package synth_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    SAT
  } mix_state_e;

  localparam int      UNITY_GAIN = 128;
  localparam int      VOL_SHIFT  = $clog2(UNITY_GAIN);
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Width of the value handed to saturate(); wide enough for any scaled mix.
  localparam int SAT_IN_W = 48;

  typedef struct packed {
    logic    clip;
    sample_t value;
  } sat_result_t;

  // Clamp a wide signed value to the 16-bit sample range and flag when clamping happened.
  function automatic sat_result_t saturate(input logic signed [SAT_IN_W-1:0] x);
    sat_result_t                 r;
    logic signed [SAT_IN_W-1:0]  hi;
    logic signed [SAT_IN_W-1:0]  lo;
    hi = SAT_IN_W'(SAMPLE_MAX);
    lo = SAT_IN_W'(SAMPLE_MIN);
    r.clip = 1'b1;
    if (x > hi) begin
      r.value = SAMPLE_MAX;
    end else if (x < lo) begin
      r.value = SAMPLE_MIN;
    end else begin
      r.clip  = 1'b0;
      r.value = x[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Bus between the voice source and the mixer: voice samples, enables and master
// volume in; mixed sample, status flags and (with MIX_PEAK_METER_EN) the peak meter out.
interface voice_mixer_if #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W   = 16,
  parameter int VOL_W      = 8
);

  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in;
  logic [NUM_VOICES-1:0]          voice_en;
  logic [VOL_W-1:0]               volume;
  logic signed [SAMPLE_W-1:0]     mix_out;
  logic                           mix_valid;
  logic                           clip;
  logic                           overrun;
  logic                           busy;
`ifdef MIX_PEAK_METER_EN
  logic [SAMPLE_W-1:0]            peak_level;
`endif

  // Voice source side: drives voices and volume, observes the mix.
  modport master (
    output voice_in, voice_en, volume,
    input  mix_out, mix_valid, clip, overrun, busy
`ifdef MIX_PEAK_METER_EN
    , input peak_level
`endif
  );

  // Mixer side.
  modport slave (
    input  voice_in, voice_en, volume,
    output mix_out, mix_valid, clip, overrun, busy
`ifdef MIX_PEAK_METER_EN
    , output peak_level
`endif
  );

endinterface

// File: rtl/lrck_edge_sync.sv
// Brings AUD_DACLRCK into the Clk domain with a 2-FF synchroniser and emits a
// one-cycle tick on each rising edge. All stages reset high so an lrck that is
// already high when reset releases does not look like a rise.
module lrck_edge_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic lrck,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift lrck through the synchroniser and remember the previous synced level.
  always_comb begin
    sync1_d = lrck;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and history registers, reset to the "lrck high" level.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/voice_mixer.sv
// Polyphonic mix stage: on each codec frame tick, snapshot the voices, sum the
// enabled ones one per cycle, apply master volume (128 = unity), saturate to
// 16 bits and present the held result with a one-cycle valid pulse.
// Optional feature macro: MIX_PEAK_METER_EN adds a decaying |mix_out| peak meter.
// The package sample type fixes SAMPLE_W at 16.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W   = 16,
  parameter int VOL_W      = 8
`ifdef MIX_PEAK_METER_EN
  , parameter int PEAK_SHIFT = 10
`endif
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          lrck,
  voice_mixer_if.slave  bus
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int PROD_W = ACC_W + VOL_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  logic tick;

  lrck_edge_sync u_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .lrck    (lrck),
    .tick    (tick)
  );

  // Per-voice view of the packed input bus.
  logic signed [SAMPLE_W-1:0] in_arr [NUM_VOICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
      assign in_arr[gi] = bus.voice_in[gi*SAMPLE_W +: SAMPLE_W];
    end
  endgenerate

  mix_state_e                 state_q, state_d;
  logic signed [SAMPLE_W-1:0] voices_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] voices_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]      en_q, en_d;
  logic [VOL_W-1:0]           vol_q, vol_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [PROD_W-1:0]   scaled_q, scaled_d;
  logic signed [SAMPLE_W-1:0] mix_out_q, mix_out_d;
  logic                       clip_q, clip_d;
  logic                       mix_valid_q, mix_valid_d;
  logic                       overrun_q, overrun_d;

  logic signed [PROD_W-1:0]   prod;
  sat_result_t                sat;
`ifdef MIX_PEAK_METER_EN
  logic [SAMPLE_W-1:0]        peak_q, peak_d, mag, decayed;
`endif

  // FSM next state, datapath and output updates for the serial mix.
  always_comb begin
    state_d     = state_q;
    voices_d    = voices_q;
    en_d        = en_q;
    vol_d       = vol_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    scaled_d    = scaled_q;
    mix_out_d   = mix_out_q;
    clip_d      = clip_q;
    mix_valid_d = 1'b0;
    overrun_d   = overrun_q;
    // Volume is zero-extended so 128..255 stay positive gains.
    prod        = PROD_W'(acc_q) * PROD_W'($signed({1'b0, vol_q}));
    sat         = saturate(SAT_IN_W'(scaled_q));
`ifdef MIX_PEAK_METER_EN
    peak_d      = peak_q;
    // -32768 has no positive 16-bit twin, so it reads as full scale.
    if (sat.value == SAMPLE_MIN) begin
      mag = SAMPLE_W'(SAMPLE_MAX);
    end else if (sat.value[15]) begin
      mag = SAMPLE_W'(-sat.value);
    end else begin
      mag = SAMPLE_W'(sat.value);
    end
    decayed = peak_q - (peak_q >> PEAK_SHIFT);
`endif

    case (state_q)
      IDLE: begin
        if (tick) begin
          voices_d = in_arr;
          en_d     = bus.voice_en;
          vol_d    = bus.volume;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(voices_q[idx_q]);
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        scaled_d = prod >>> VOL_SHIFT;
        state_d  = SAT;
      end
      SAT: begin
        mix_out_d   = sat.value;
        clip_d      = sat.clip;
        mix_valid_d = 1'b1;
`ifdef MIX_PEAK_METER_EN
        peak_d      = (mag > decayed) ? mag : decayed;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A frame tick that the FSM cannot accept is recorded, never queued.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any mix in progress.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      voices_q    <= '{default: '0};
      en_q        <= '0;
      vol_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      scaled_q    <= '0;
      mix_out_q   <= '0;
      clip_q      <= 1'b0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef MIX_PEAK_METER_EN
      peak_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      voices_q    <= voices_d;
      en_q        <= en_d;
      vol_q       <= vol_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      scaled_q    <= scaled_d;
      mix_out_q   <= mix_out_d;
      clip_q      <= clip_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
`ifdef MIX_PEAK_METER_EN
      peak_q      <= peak_d;
`endif
    end
  end

  assign bus.mix_out   = mix_out_q;
  assign bus.mix_valid = mix_valid_q;
  assign bus.clip      = clip_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef MIX_PEAK_METER_EN
  assign bus.peak_level = peak_q;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed frames with literal expected results, plus a
// cycle-level reference model (sum * volume / 128, clamp) compared every cycle.
module tb_voice_mixer;

  localparam int NV = 8;
  localparam int SW = 16;
  localparam int VW = 8;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic lrck    = 1'b0;

  voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW)) vif ();

  voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .lrck    (lrck),
    .bus     (vif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  bit m_h1 = 1'b1, m_h2 = 1'b1, m_h3 = 1'b1;  // lrck as seen at the last three edges
  int m_cnt = 0;                               // cycles until the pending mix appears
  int m_pend_v = 0;
  bit m_pend_c = 1'b0;
  int m_out = 0;
  bit m_clip = 1'b0;
  bit m_valid = 1'b0;
  bit m_overrun = 1'b0;
  int m_peak = 0;

  task automatic mix_expect(output int v, output bit c);
    longint sum;
    longint p;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (vif.voice_en[i]) sum += longint'($signed(vif.voice_in[i*SW +: SW]));
    end
    p = (sum * longint'(vif.volume)) >>> 7;
    if (p > 32767) begin
      v = 32767; c = 1'b1;
    end else if (p < -32768) begin
      v = -32768; c = 1'b1;
    end else begin
      v = int'(p); c = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tk;
    int mag;
    int dec;
    cyc++;
    if (!rst_n) begin
      m_h1 = 1'b1; m_h2 = 1'b1; m_h3 = 1'b1;
      m_cnt = 0; m_out = 0; m_clip = 1'b0; m_valid = 1'b0;
      m_overrun = 1'b0; m_peak = 0;
    end else begin
      // A rise becomes usable two edges after it is first sampled.
      tk = m_h2 & ~m_h3;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = lrck;
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        if (tk) m_overrun = 1'b1;
        m_cnt--;
        if (m_cnt == 0) begin
          m_out = m_pend_v; m_clip = m_pend_c; m_valid = 1'b1;
          mag = (m_out == -32768) ? 32767 : ((m_out < 0) ? -m_out : m_out);
          dec = m_peak - (m_peak >> 10);
          m_peak = (mag > dec) ? mag : dec;
        end
      end else if (tk) begin
        mix_expect(m_pend_v, m_pend_c);
        m_cnt = 10;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("mix_valid", vif.mix_valid, m_valid);
      check("busy", vif.busy, (m_cnt > 0));
      check("overrun", vif.overrun, m_overrun);
      check("mix_out", vif.mix_out, m_out);
      check("clip", vif.clip, m_clip);
`ifdef MIX_PEAK_METER_EN
      check("peak_level", vif.peak_level, m_peak);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_voices(input int v0, input int v1, input int rest,
                            input logic [7:0] en, input logic [7:0] vol);
    for (int i = 0; i < NV; i++) begin
      vif.voice_in[i*SW +: SW] = (i == 0) ? SW'(v0) : ((i == 1) ? SW'(v1) : SW'(rest));
    end
    vif.voice_en = en;
    vif.volume   = vol;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One lrck rise; expects exactly one valid 13 edges later with the given result.
  task automatic run_mix(input string name, input int exp_out, input bit exp_clip,
                         input bit disturb);
    bit got;
    got = 1'b0;
    @(negedge clk); lrck = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4) lrck = 1'b0;
      if (disturb && i == 6) begin
        vif.voice_in = '1; vif.voice_en = '1; vif.volume = 8'd200;
      end
      if (!got && vif.mix_valid === 1'b1) begin
        got = 1'b1;
        check({name, "_latency"}, i, 13);
        check({name, "_out"}, vif.mix_out, exp_out);
        check({name, "_clip"}, vif.clip, exp_clip);
      end
    end
    check({name, "_seen"}, got, 1);
    $display("mix %s: out=%0d clip=%0b overrun=%0b", name, vif.mix_out, vif.clip, vif.overrun);
  endtask

  int n_valid;

  initial begin
    vif.voice_in = '0; vif.voice_en = '0; vif.volume = 8'd128;
    repeat (3) @(negedge clk);
    check("reset_mix_out", vif.mix_out, 0);
    check("reset_busy", vif.busy, 0);
    check("reset_overrun", vif.overrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    set_voices(1000, -300, 0, 8'h03, 8'd128);   run_mix("basic", 700, 1'b0, 1'b0);
    set_voices(32767, 32767, 32767, 8'hFF, 8'd128); run_mix("sat_hi", 32767, 1'b1, 1'b0);
    set_voices(-32768, -32768, -32768, 8'hFF, 8'd128); run_mix("sat_lo", -32768, 1'b1, 1'b0);
    set_voices(4000, 0, 0, 8'h01, 8'd64);       run_mix("vol64", 2000, 1'b0, 1'b1);
    set_voices(4000, 0, 0, 8'h01, 8'd255);      run_mix("vol255", 7968, 1'b0, 1'b0);
    set_voices(4000, 0, 0, 8'h01, 8'd0);        run_mix("vol0", 0, 1'b0, 1'b0);
    set_voices(1234, 5678, 99, 8'h00, 8'd128);  run_mix("all_off", 0, 1'b0, 1'b0);

    // Second rise five cycles after the first tick.
    set_voices(1000, -300, 0, 8'h03, 8'd128);
    n_valid = 0;
    @(negedge clk); lrck = 1'b1;
    repeat (2) @(negedge clk); lrck = 1'b0;
    repeat (3) @(negedge clk); lrck = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (i == 3) lrck = 1'b0;
      if (vif.mix_valid === 1'b1) n_valid++;
    end
    check("overrun_valid_count", n_valid, 1);
    check("overrun_set", vif.overrun, 1);
    $display("overrun frame: valids=%0d overrun=%0b", n_valid, vif.overrun);
    run_mix("after_overrun", 700, 1'b0, 1'b0);
    check("overrun_sticky", vif.overrun, 1);
    do_reset();
    @(negedge clk);
    check("overrun_cleared", vif.overrun, 0);

    // Reset in the middle of accumulation, lrck held high through release.
    run_mix("pre_abort", 700, 1'b0, 1'b0);
    @(negedge clk); lrck = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_busy_before", vif.busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (vif.mix_valid === 1'b1) n_valid++;
    end
    check("abort_no_valid", n_valid, 0);
    check("abort_mix_out", vif.mix_out, 0);
    check("abort_busy", vif.busy, 0);
    $display("abort: valids=%0d mix_out=%0d busy=%0b", n_valid, vif.mix_out, vif.busy);
    lrck = 1'b0;
    repeat (3) @(negedge clk);
    run_mix("post_abort", 700, 1'b0, 1'b0);

    // Peak meter: a loud mix then silence.
    do_reset();
    repeat (2) @(negedge clk);
    set_voices(-20000, 0, 0, 8'h01, 8'd128);    run_mix("peak_loud", -20000, 1'b0, 1'b0);
`ifdef MIX_PEAK_METER_EN
    check("peak_after_loud", vif.peak_level, 20000);
`endif
    set_voices(0, 0, 0, 8'h00, 8'd128);         run_mix("peak_quiet", 0, 1'b0, 1'b0);
`ifdef MIX_PEAK_METER_EN
    check("peak_after_quiet", vif.peak_level, 19981);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
